// File: rtl/nn_pkg.sv
// rtl/nn_pkg.sv - shared constants and state encoding for the neuron array training path
package nn_pkg;

  localparam int N_HIDDEN_DEF = 8;
  localparam int LOSS_W_DEF   = 46;
  localparam int X_W_DEF      = 4;

  typedef logic [2:0] state_t;

  localparam state_t S_IDLE    = 3'd0;
  localparam state_t S_WAIT_X  = 3'd1;
  localparam state_t S_FWD_HID = 3'd2;
  localparam state_t S_FWD_OUT = 3'd3;
  localparam state_t S_LOSS    = 3'd4;
  localparam state_t S_UPDATE  = 3'd5;
  localparam state_t S_NEXT    = 3'd6;
  localparam state_t S_DONE    = 3'd7;

endpackage

// File: rtl/nn_phase_timer.sv
// rtl/nn_phase_timer.sv - loadable down-counter; tc is high while the count sits at zero
module nn_phase_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         tc
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst)
      cnt <= '0;
    else if (load)
      cnt <= load_val;
    else if (cnt != '0)
      cnt <= cnt - 1'b1;
  end

  assign tc = (cnt == '0);

endmodule

// File: rtl/nn_train_sequencer.sv
// rtl/nn_train_sequencer.sv - sample intake, forward-pass enables, loss capture and weight-update walk
module nn_train_sequencer
  import nn_pkg::*;
#(
  parameter int N_HIDDEN = N_HIDDEN_DEF,
  parameter int HID_LAT  = 2,
  parameter int OUT_LAT  = 3,
  parameter int EPOCHS   = 16,
  parameter int LOSS_W   = LOSS_W_DEF,
  parameter int X_W      = X_W_DEF,
  parameter int SEL_W    = $clog2(N_HIDDEN + 1)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [X_W-1:0]    x_i,
  input  logic              x_valid_i,
  output logic              x_ready_o,
  output logic [X_W-1:0]    hid_x_o,
  output logic              hid_en_o,
  output logic              out_en_o,
  input  logic [LOSS_W-1:0] loss_i,
  output logic [LOSS_W-1:0] loss_q_o,
  output logic              upd_en_o,
  output logic [SEL_W-1:0]  upd_sel_o,
  input  logic              upd_ack_i,
  output logic [7:0]        epoch_o,
  output logic              busy_o,
  output logic              done_o
);

  localparam logic [7:0]       HID_LOAD  = 8'(HID_LAT - 1);
  localparam logic [7:0]       OUT_LOAD  = 8'(OUT_LAT - 1);
  localparam logic [SEL_W-1:0] SEL_LAST  = SEL_W'(N_HIDDEN);
  localparam logic [7:0]       EPOCH_END = 8'(EPOCHS);

  state_t     state;
  logic       tmr_load;
  logic [7:0] tmr_val;
  logic       tmr_tc;
  logic [7:0] epoch_nxt;

  assign epoch_nxt = epoch_o + 8'd1;

  // The timer is armed on entry to each forward phase so tc marks that phase's last cycle.
  always_comb begin
    tmr_load = 1'b0;
    tmr_val  = HID_LOAD;
    if (state == S_WAIT_X && x_valid_i) begin
      tmr_load = 1'b1;
    end else if (state == S_FWD_HID && tmr_tc) begin
      tmr_load = 1'b1;
      tmr_val  = OUT_LOAD;
    end
  end

  nn_phase_timer #(.W(8)) u_timer (
    .clk      (clk_i),
    .rst      (rst_i),
    .load     (tmr_load),
    .load_val (tmr_val),
    .tc       (tmr_tc)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= S_IDLE;
      hid_x_o   <= '0;
      loss_q_o  <= '0;
      upd_sel_o <= '0;
      epoch_o   <= '0;
    end else begin
      case (state)
        S_IDLE: if (start_i) begin
          epoch_o <= '0;
          state   <= S_WAIT_X;
        end
        S_WAIT_X: if (x_valid_i) begin
          hid_x_o <= x_i;
          state   <= S_FWD_HID;
        end
        S_FWD_HID: if (tmr_tc) state <= S_FWD_OUT;
        S_FWD_OUT: if (tmr_tc) state <= S_LOSS;
        S_LOSS: begin
          loss_q_o <= loss_i;
          if (loss_i == '0) begin
            state <= S_NEXT;
          end else begin
            upd_sel_o <= '0;
            state     <= S_UPDATE;
          end
        end
        S_UPDATE: if (upd_ack_i) begin
          if (upd_sel_o == SEL_LAST)
            state <= S_NEXT;
          else
            upd_sel_o <= upd_sel_o + 1'b1;
        end
        S_NEXT: begin
          epoch_o <= epoch_nxt;
          state   <= (epoch_nxt == EPOCH_END) ? S_DONE : S_WAIT_X;
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign x_ready_o = (state == S_WAIT_X);
  assign hid_en_o  = (state == S_FWD_HID);
  assign out_en_o  = (state == S_FWD_OUT);
  assign upd_en_o  = (state == S_UPDATE);
  assign done_o    = (state == S_DONE);
  assign busy_o    = (state != S_IDLE);

endmodule

// File: tb/tb_nn_train_sequencer.sv
// tb/tb_nn_train_sequencer.sv - randomized bench for nn_train_sequencer against a transaction-level model
module tb_nn_train_sequencer;

  localparam int HID = 2;
  localparam int OUT = 3;
  localparam int NH  = 8;
  localparam int EP  = 4;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        start_i;
  logic [3:0]  x_i;
  logic        x_valid_i;
  logic        x_ready_o;
  logic [3:0]  hid_x_o;
  logic        hid_en_o;
  logic        out_en_o;
  logic [45:0] loss_i;
  logic [45:0] loss_q_o;
  logic        upd_en_o;
  logic [3:0]  upd_sel_o;
  logic        upd_ack_i;
  logic [7:0]  epoch_o;
  logic        busy_o;
  logic        done_o;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  int          gap [EP];
  logic [3:0]  xs  [EP];
  logic [45:0] lss [EP];
  int          dly [EP][NH+1];

  always #5 clk = ~clk;

  nn_train_sequencer #(.EPOCHS(EP)) dut (
    .clk_i     (clk),
    .rst_i     (rst_i),
    .start_i   (start_i),
    .x_i       (x_i),
    .x_valid_i (x_valid_i),
    .x_ready_o (x_ready_o),
    .hid_x_o   (hid_x_o),
    .hid_en_o  (hid_en_o),
    .out_en_o  (out_en_o),
    .loss_i    (loss_i),
    .loss_q_o  (loss_q_o),
    .upd_en_o  (upd_en_o),
    .upd_sel_o (upd_sel_o),
    .upd_ack_i (upd_ack_i),
    .epoch_o   (epoch_o),
    .busy_o    (busy_o),
    .done_o    (done_o)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_ready"}, x_ready_o, 0);
    chk({tag, "_hid_en"}, hid_en_o, 0);
    chk({tag, "_out_en"}, out_en_o, 0);
    chk({tag, "_upd_en"}, upd_en_o, 0);
    chk({tag, "_busy"}, busy_o, 0);
    chk({tag, "_done"}, done_o, 0);
    chk({tag, "_hid_x"}, hid_x_o, 0);
    chk({tag, "_loss_q"}, loss_q_o, 0);
    chk({tag, "_upd_sel"}, upd_sel_o, 0);
    chk({tag, "_epoch"}, epoch_o, 0);
  endtask

  task automatic fill(input int g, input int d, input logic [45:0] l, input bit rnd);
    logic [63:0] r;
    for (int i = 0; i < EP; i++) begin
      gap[i] = rnd ? int'($urandom_range(0, 6)) : g;
      xs[i]  = rnd ? 4'($urandom_range(0, 15)) : 4'hA;
      if (rnd) begin
        r = {$urandom, $urandom};
        lss[i] = ($urandom_range(0, 2) == 0) ? 46'd0 : ((r[45:0] == 46'd0) ? 46'd1 : r[45:0]);
      end else begin
        lss[i] = l;
      end
      for (int k = 0; k <= NH; k++) dly[i][k] = rnd ? int'($urandom_range(0, 3)) : d;
    end
  endtask

  // Expected timing is built from phase durations: WAIT_X dwell, forward dwells, LOSS, one
  // request per neuron (delay+1 cycles each) when loss is nonzero, and NEXT.
  task automatic run(input bit junk, input bit abort4, input int want_rel);
    int s, smp, wcnt, req, dw, acc, hid_n, hid_f, out_n, out_f, acks, upd_n;
    int exp_rel, exp_acks, exp_upd;
    bit fin, have_acc;
    exp_rel = 1; exp_acks = 0; exp_upd = 0;
    for (int i = 0; i < EP; i++) begin
      exp_rel += gap[i] + 1 + HID + OUT + 2;
      if (lss[i] != 46'd0) begin
        exp_acks += NH + 1;
        for (int k = 0; k <= NH; k++) begin
          exp_rel += dly[i][k] + 1;
          exp_upd += dly[i][k] + 1;
        end
      end
    end
    smp = 0; wcnt = 0; req = 0; dw = 0; acc = 0; acks = 0; upd_n = 0;
    hid_n = 0; out_n = 0; hid_f = -1; out_f = -1;
    fin = 0; have_acc = 0;
    start_i = 1'b1; s = cyc;
    tick();
    start_i = 1'b0;
    chk("busy_after_start", busy_o, 1);
    chk("ready_after_start", x_ready_o, 1);
    while (!fin) begin
      if (cyc - s > exp_rel + 20) begin
        chk("timeout", cyc - s, exp_rel);
        fin = 1;
      end else begin
        if (hid_en_o) begin if (hid_n == 0) hid_f = cyc; hid_n++; end
        if (out_en_o) begin if (out_n == 0) out_f = cyc; out_n++; end
        if (have_acc && cyc == acc + 1) chk("hid_x", hid_x_o, xs[smp-1]);
        if (have_acc && cyc == acc + HID + OUT + 1) begin
          chk("hid_first", hid_f, acc + 1);
          chk("hid_len", hid_n, HID);
          chk("out_first", out_f, acc + 1 + HID);
          chk("out_len", out_n, OUT);
          hid_n = 0; out_n = 0; hid_f = -1; out_f = -1;
        end
        if (have_acc && cyc == acc + HID + OUT + 2) chk("loss_q", loss_q_o, lss[smp-1]);

        x_valid_i = 1'b0; upd_ack_i = 1'b0; start_i = 1'b0;
        if (junk) begin
          if (!x_ready_o) begin x_valid_i = 1'($urandom_range(0, 1)); x_i = 4'($urandom_range(0, 15)); end
          if (!upd_en_o) upd_ack_i = 1'($urandom_range(0, 1));
          if (busy_o) start_i = 1'($urandom_range(0, 1));
        end

        if (done_o) begin
          chk("done_cycle", cyc - s, exp_rel);
          if (want_rel >= 0) chk("done_cycle_plan", cyc - s, want_rel);
          chk("epoch_at_done", epoch_o, EP);
          chk("acks", acks, exp_acks);
          chk("upd_cycles", upd_n, exp_upd);
          x_valid_i = 1'b0; upd_ack_i = 1'b0; start_i = 1'b0;
          tick();
          chk("done_pulse", done_o, 0);
          chk("idle_after_done", busy_o, 0);
          fin = 1;
        end else if (x_ready_o) begin
          if (smp >= EP) begin
            chk("samples", smp, EP - 1);
            fin = 1;
          end else begin
            if (wcnt == 0) chk("epoch_in_wait", epoch_o, smp);
            if (wcnt == gap[smp]) begin
              x_valid_i = 1'b1; x_i = xs[smp]; loss_i = lss[smp];
              acc = cyc; have_acc = 1; smp++;
              wcnt = 0; req = 0; dw = 0;
            end else begin
              wcnt++;
            end
          end
        end else if (upd_en_o) begin
          upd_n++;
          if (!have_acc || req > NH) begin
            chk("upd_unexpected", req, NH);
            fin = 1;
          end else begin
            chk("upd_sel", upd_sel_o, req);
            if (abort4 && req == 4) begin
              rst_i = 1'b1;
              tick();
              rst_i = 1'b0;
              chk_zero("after_abort");
              fin = 1;
            end else if (dw == dly[smp-1][req]) begin
              upd_ack_i = 1'b1; acks++; req++; dw = 0;
            end else begin
              dw++;
            end
          end
        end
        if (!fin) tick();
      end
    end
  endtask

  initial begin
    rst_i = 1'b1; start_i = 1'b1; x_i = 4'h0; x_valid_i = 1'b1; loss_i = 46'd7; upd_ack_i = 1'b1;
    tick();
    tick();
    chk_zero("reset");
    rst_i = 1'b0; start_i = 1'b0; x_valid_i = 1'b0; upd_ack_i = 1'b0; loss_i = 46'd0;
    tick();
    chk("idle_no_start", busy_o, 0);

    fill(0, 0, 46'd5, 0); run(0, 0, 69);
    fill(0, 0, 46'd0, 0); run(0, 0, 33);
    fill(0, 3, 46'd5, 0); run(0, 0, 177);
    fill(5, 0, 46'd5, 0); run(0, 0, 89);
    fill(0, 0, 46'd5, 0); run(1, 0, 69);
    fill(0, 0, 46'd5, 0); run(0, 1, -1);
    fill(0, 0, 46'd5, 0); run(0, 0, 69);
    for (int t = 0; t < 6; t++) begin
      fill(0, 0, 46'd0, 1);
      run(1'(t % 2), 0, -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
